// File: rtl/watch_pkg.sv
// Shared definitions for the stopwatch display scanner: digit layout, 7-segment
// pattern table, scan FSM encoding and decimal-point placement.
package watch_pkg;

  localparam int unsigned DigitCount = 6;

  // Digit indices within dispbuf, nibble i occupies [4*i+3:4*i]
  localparam logic [2:0] DigMsec1   = 3'd0;
  localparam logic [2:0] DigMsec2   = 3'd1;
  localparam logic [2:0] DigSec0    = 3'd2;
  localparam logic [2:0] DigSec1    = 3'd3;
  localparam logic [2:0] DigMinute0 = 3'd4;
  localparam logic [2:0] DigMinute1 = 3'd5;

  // Decimal points after sec0 and minute0: MM.SS.ms
  localparam logic [DigitCount-1:0] DpMask = 6'b010100;

  // Active-high patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SegDash = 7'h40;

  typedef enum logic [1:0] {
    StIdle,
    StBlank,
    StShow
  } scan_state_e;

  function automatic logic [6:0] seg7_pattern(logic [3:0] bcd);
    logic [6:0] pat;
    case (bcd)
      4'h0:    pat = 7'h3F;
      4'h1:    pat = 7'h06;
      4'h2:    pat = 7'h5B;
      4'h3:    pat = 7'h4F;
      4'h4:    pat = 7'h66;
      4'h5:    pat = 7'h6D;
      4'h6:    pat = 7'h7D;
      4'h7:    pat = 7'h07;
      4'h8:    pat = 7'h7F;
      4'h9:    pat = 7'h6F;
      default: pat = SegDash;
    endcase
    return pat;
  endfunction

  function automatic logic [3:0] nibble_of(logic [23:0] dbuf, logic [2:0] idx);
    logic [3:0] nib;
    case (idx)
      3'd0:    nib = dbuf[3:0];
      3'd1:    nib = dbuf[7:4];
      3'd2:    nib = dbuf[11:8];
      3'd3:    nib = dbuf[15:12];
      3'd4:    nib = dbuf[19:16];
      3'd5:    nib = dbuf[23:20];
      default: nib = 4'h0;
    endcase
    return nib;
  endfunction

endpackage

// File: rtl/watch_disp_scan_if.sv
// Display scanner signal bundle: time buffer and enable in, multiplexed
// 7-segment drive out.
interface watch_disp_scan_if;

  logic        en;
  logic [23:0] dispbuf;
  logic [6:0]  seg;
  logic        dp;
  logic [5:0]  an;
  logic        frame_start;

  modport master (
    output en,
    output dispbuf,
    input  seg,
    input  dp,
    input  an,
    input  frame_start
  );

  modport slave (
    input  en,
    input  dispbuf,
    output seg,
    output dp,
    output an,
    output frame_start
  );

endinterface

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to 7-segment decoder, active-high {g,f,e,d,c,b,a};
// non-decimal nibbles decode to a dash.
module bcd_to_seg7
  import watch_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  assign seg_o = seg7_pattern(bcd_i);

endmodule

// File: rtl/watch_disp_scan.sv
// Six-digit multiplexed 7-segment scanner with per-frame snapshot and blanking slots.
// Define WATCH_DISP_LZB_EN to blank leading zeros of the minutes field.
module watch_disp_scan
  import watch_pkg::*;
#(
  parameter int unsigned DWELL          = 2,
  parameter int unsigned BLANK          = 1,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
  input logic              clk_1Khz,
  input logic              rst,
  watch_disp_scan_if.slave disp
);

  localparam int unsigned MaxCnt = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int unsigned CntW   = (MaxCnt > 1) ? $clog2(MaxCnt) : 1;

  localparam logic [CntW-1:0]       BlankLast = CntW'(BLANK - 1);
  localparam logic [CntW-1:0]       DwellLast = CntW'(DWELL - 1);
  localparam logic [2:0]            DigitLast = 3'(DigitCount - 1);
  localparam logic [6:0]            SegOff    = {7{SEG_ACTIVE_LOW}};
  localparam logic [DigitCount-1:0] AnOff     = {DigitCount{AN_ACTIVE_LOW}};

  scan_state_e state_q, state_d;
  logic [2:0]      digit_q, digit_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [23:0]     snap_q, snap_d;
  logic            fs_d;

  logic [6:0]            seg_q;
  logic                  dp_q;
  logic [DigitCount-1:0] an_q;
  logic                  fs_q;

  logic [3:0]            cur_nibble;
  logic [6:0]            dec_seg;
  logic [6:0]            seg_on;
  logic                  dp_on;
  logic [DigitCount-1:0] an_on;

  // Next-state logic. Dropping en aborts the frame from any state.
  always_comb begin
    state_d = state_q;
    digit_d = digit_q;
    cnt_d   = cnt_q;
    snap_d  = snap_q;
    fs_d    = 1'b0;
    if (!disp.en) begin
      state_d = StIdle;
      digit_d = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d = StBlank;
          digit_d = '0;
          cnt_d   = '0;
          snap_d  = disp.dispbuf;
          fs_d    = 1'b1;
        end
        StBlank: begin
          if (cnt_q == BlankLast) begin
            state_d = StShow;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StShow: begin
          if (cnt_q == DwellLast) begin
            state_d = StBlank;
            cnt_d   = '0;
            if (digit_q == DigitLast) begin
              digit_d = '0;
              snap_d  = disp.dispbuf;
              fs_d    = 1'b1;
            end else begin
              digit_d = digit_q + 3'd1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = StIdle;
          digit_d = '0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Decode from next-state values so the registered outputs line up with the FSM.
  assign cur_nibble = nibble_of(snap_d, digit_d);

  bcd_to_seg7 u_dec (
    .bcd_i (cur_nibble),
    .seg_o (dec_seg)
  );

  always_comb begin
    an_on  = '0;
    seg_on = '0;
    dp_on  = 1'b0;
    if (state_d == StShow) begin
      an_on  = {{(DigitCount-1){1'b0}}, 1'b1} << digit_d;
      seg_on = dec_seg;
      dp_on  = DpMask[digit_d];
`ifdef WATCH_DISP_LZB_EN
      if (nibble_of(snap_d, DigMinute1) == 4'h0) begin
        if (digit_d == DigMinute1) begin
          seg_on = '0;
          dp_on  = 1'b0;
        end
        // minute0 keeps its dp so the MM.SS separator stays visible
        if (digit_d == DigMinute0 && nibble_of(snap_d, DigMinute0) == 4'h0) begin
          seg_on = '0;
        end
      end
`endif
    end
  end

  always_ff @(posedge clk_1Khz or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      digit_q <= '0;
      cnt_q   <= '0;
      snap_q  <= '0;
      seg_q   <= SegOff;
      dp_q    <= SEG_ACTIVE_LOW;
      an_q    <= AnOff;
      fs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      digit_q <= digit_d;
      cnt_q   <= cnt_d;
      snap_q  <= snap_d;
      seg_q   <= seg_on ^ SegOff;
      dp_q    <= dp_on ^ SEG_ACTIVE_LOW;
      an_q    <= an_on ^ AnOff;
      fs_q    <= fs_d;
    end
  end

  assign disp.seg         = seg_q;
  assign disp.dp          = dp_q;
  assign disp.an          = an_q;
  assign disp.frame_start = fs_q;

endmodule

// File: tb/tb_watch_disp_scan.sv
// Randomized bench for watch_disp_scan against a frame-time reference model:
// expected outputs follow from the cycle offset within the frame and the frame snapshot.
module tb_watch_disp_scan;

  localparam int unsigned Dwell = 2;
  localparam int unsigned Blank = 1;
  localparam int unsigned Slot  = Blank + Dwell;
  localparam int unsigned Frame = 6 * Slot;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  watch_disp_scan_if disp ();

  watch_disp_scan #(
    .DWELL          (Dwell),
    .BLANK          (Blank),
    .SEG_ACTIVE_LOW (1'b1),
    .AN_ACTIVE_LOW  (1'b1)
  ) dut (
    .clk_1Khz (clk),
    .rst      (rst),
    .disp     (disp)
  );

  int checks = 0;
  int errors = 0;

  // Lit segments per decimal digit, by segment letter
  string digit_letters [10] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg",
                                "acdfg", "acdefg", "abc", "abcdefg", "abcdfg"};

  // Reference model: running flag, cycle offset in frame, frame snapshot
  bit          running = 1'b0;
  int          t       = 0;
  logic [23:0] snap    = '0;
  bit          fs_exp  = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0d snap=%h) @%0t", tag, got, exp, t, snap,
               $time);
    end
  endtask

  function automatic logic [6:0] seg_from_letters(input string s);
    logic [6:0] r = '0;
    for (int i = 0; i < s.len(); i++) r[int'(s[i]) - 97] = 1'b1;
    return r;
  endfunction

  task automatic model_step(input logic en_s, input logic [23:0] buf_s);
    fs_exp = 1'b0;
    if (!en_s) begin
      running = 1'b0;
    end else if (!running) begin
      running = 1'b1;
      t       = 0;
      snap    = buf_s;
      fs_exp  = 1'b1;
    end else begin
      t++;
      if (t == Frame) begin
        t      = 0;
        snap   = buf_s;
        fs_exp = 1'b1;
      end
    end
  endtask

  task automatic check_outputs();
    logic [5:0] an_lit  = '0;
    logic [6:0] seg_lit = '0;
    logic       dp_lit  = 1'b0;
    logic [5:0] an_e;
    logic [6:0] seg_e;
    logic       dp_e;
    logic [3:0] nib;
    int         d;
    if (running && (t % Slot) >= Blank) begin
      d          = t / Slot;
      nib        = snap[4*d +: 4];
      an_lit[d]  = 1'b1;
      seg_lit    = (nib < 10) ? seg_from_letters(digit_letters[nib]) : seg_from_letters("g");
      dp_lit     = (d == 2 || d == 4);
`ifdef WATCH_DISP_LZB_EN
      if (snap[23:20] == 4'h0) begin
        if (d == 5) begin
          seg_lit = '0;
          dp_lit  = 1'b0;
        end
        if (d == 4 && snap[19:16] == 4'h0) seg_lit = '0;
      end
`endif
    end
    an_e  = ~an_lit;
    seg_e = ~seg_lit;
    dp_e  = ~dp_lit;
    check("an", disp.an, an_e);
    check("seg", disp.seg, seg_e);
    check("dp", disp.dp, dp_e);
    check("frame_start", disp.frame_start, fs_exp);
  endtask

  task automatic run_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      model_step(disp.en, disp.dispbuf);
      #1;
      check_outputs();
    end
  endtask

  task automatic check_reset_state();
    check("rst_an", disp.an, 32'h3F);
    check("rst_seg", disp.seg, 32'h7F);
    check("rst_dp", disp.dp, 32'h1);
    check("rst_frame_start", disp.frame_start, 32'h0);
  endtask

  // Called just after a post-edge check; asserts reset between edges
  task automatic async_reset();
    #2 rst = 1'b0;
    #1 check_reset_state();
    running = 1'b0;
    t       = 0;
    snap    = '0;
    fs_exp  = 1'b0;
    @(posedge clk);
    #1 check_reset_state();
    @(negedge clk);
    rst = 1'b1;
  endtask

  function automatic logic [23:0] rand_buf();
    logic [23:0] b;
    for (int k = 0; k < 6; k++) begin
      b[4*k +: 4] = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(10, 15))
                                                 : 4'($urandom_range(0, 9));
    end
    if ($urandom_range(0, 3) == 0) b[23:20] = 4'h0;
    if ($urandom_range(0, 5) == 0) b[23:16] = 8'h00;
    return b;
  endfunction

  initial begin
    rst          = 1'b0;
    disp.en      = 1'b0;
    disp.dispbuf = '0;
    #12 check_reset_state();
    @(negedge clk);
    rst = 1'b1;

    // Plain scan
    disp.en      = 1'b1;
    disp.dispbuf = 24'h123456;
    run_cycles(3 * Frame + 2);

    // Tearing: new value arrives during digit 2 of a zero frame
    disp.en = 1'b0;
    run_cycles(2);
    disp.en      = 1'b1;
    disp.dispbuf = 24'h000000;
    run_cycles(8);
    disp.dispbuf = 24'h595999;
    run_cycles(2 * Frame);

    // Invalid BCD nibbles
    disp.dispbuf = 24'hF0A000;
    run_cycles(2 * Frame);

    // Enable dropped during digit 3, then re-raised
    disp.en = 1'b0;
    run_cycles(1);
    disp.en = 1'b1;
    run_cycles(11);
    disp.en = 1'b0;
    run_cycles(3);
    disp.en = 1'b1;
    run_cycles(Frame + 4);

    // Leading-zero case
    disp.dispbuf = 24'h000512;
    run_cycles(2 * Frame);

    // Async reset mid-frame
    run_cycles(7);
    async_reset();
    run_cycles(Frame + 5);

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 399) == 0) async_reset();
      disp.en = ($urandom_range(0, 39) != 0);
      if ($urandom_range(0, 7) == 0) disp.dispbuf = rand_buf();
      run_cycles(1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
